// File: rtl/regfile_dump_ctrl.sv
// End-of-run register dump sequencer: runs the CPU for a set number of cycles, then scans the regfile out over a valid/ready stream.
// Optional build macro DUMP_SKIP_R0_EN starts the scan at r1 instead of r0.
module regfile_dump_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int CYC_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CYC_W-1:0] run_cycles,
  input  logic [4:0]       cpu_readRegA,
  input  logic             cpu_writeEnable,
  output logic [4:0]       rf_readRegA,
  output logic             rf_writeEnable,
  input  logic [31:0]      data_readRegA,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [4:0]       dump_reg,
  output logic [31:0]      dump_data,
  output logic             busy,
  output logic             done,
  output logic [CYC_W-1:0] cycle_count
);

`ifdef DUMP_SKIP_R0_EN
  localparam logic [4:0] FIRST_IDX = 5'd1;
`else
  localparam logic [4:0] FIRST_IDX = 5'd0;
`endif
  localparam logic [4:0]       LAST_IDX = 5'(NUM_REGS - 1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SCAN,
    HOLD,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [CYC_W-1:0] run_len;
  logic [4:0]       idx;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (run_cycles == '0) ? SCAN : RUN;
      RUN:        if (cycle_count == run_len - CYC_ONE) state_next = SCAN;
      SCAN:       state_next = HOLD;
      HOLD:       if (dump_ready) state_next = (idx == LAST_IDX) ? DONE : SCAN;
      default:    state_next = IDLE;
    endcase
  end

  // The regfile only sees the controller's select while a beat is in flight.
  always_comb begin
    rf_readRegA    = cpu_readRegA;
    rf_writeEnable = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: rf_writeEnable = cpu_writeEnable;
      RUN: begin
        rf_writeEnable = cpu_writeEnable;
        busy           = 1'b1;
      end
      SCAN, HOLD: begin
        rf_readRegA = idx;
        busy        = 1'b1;
      end
      DONE:    done = 1'b1;
      default: rf_writeEnable = cpu_writeEnable;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      run_len     <= '0;
      cycle_count <= '0;
      idx         <= FIRST_IDX;
      dump_valid  <= 1'b0;
      dump_reg    <= '0;
      dump_data   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            run_len     <= run_cycles;
            cycle_count <= '0;
            idx         <= FIRST_IDX;
          end
        end
        RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + CYC_ONE;
        end
        SCAN: begin
          dump_data  <= data_readRegA;
          dump_reg   <= idx;
          dump_valid <= 1'b1;
        end
        HOLD: begin
          // Index stops at the last register so it never wraps.
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (idx != LAST_IDX) idx <= idx + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl with a combinational regfile model preloaded rN = 3*N.
module tb_regfile_dump_ctrl;

  localparam int NUM_REGS = 32;
  localparam int CYC_W    = 16;
`ifdef DUMP_SKIP_R0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NB = NUM_REGS - FIRST;

  logic             clock;
  logic             reset;
  logic             start;
  logic [CYC_W-1:0] run_cycles;
  logic [4:0]       cpu_readRegA;
  logic             cpu_writeEnable;
  logic [4:0]       rf_readRegA;
  logic             rf_writeEnable;
  logic [31:0]      data_readRegA;
  logic             dump_valid;
  logic             dump_ready;
  logic [4:0]       dump_reg;
  logic [31:0]      dump_data;
  logic             busy;
  logic             done;
  logic [CYC_W-1:0] cycle_count;

  logic [31:0] rf_mem [NUM_REGS];
  int testsRun;
  int testsFailed;
  int busyCycles;

  regfile_dump_ctrl #(.NUM_REGS(NUM_REGS), .CYC_W(CYC_W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .run_cycles(run_cycles),
    .cpu_readRegA(cpu_readRegA),
    .cpu_writeEnable(cpu_writeEnable),
    .rf_readRegA(rf_readRegA),
    .rf_writeEnable(rf_writeEnable),
    .data_readRegA(data_readRegA),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_reg(dump_reg),
    .dump_data(dump_data),
    .busy(busy),
    .done(done),
    .cycle_count(cycle_count)
  );

  assign data_readRegA = rf_mem[rf_readRegA];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [CYC_W-1:0] rc, input logic rdy);
    start      = s;
    run_cycles = rc;
    dump_ready = rdy;
  endtask

  task automatic stepClock();
    @(posedge clock);
    #1;
    if (busy === 1'b1) busyCycles++;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    busyCycles  = 0;
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = 32'(3 * i);
    reset           = 1'b0;
    cpu_readRegA    = 5'd17;
    cpu_writeEnable = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b1);
    stepClock();
    stepClock();

    checkOutput("rst_valid", 32'(dump_valid), 32'd0);
    checkOutput("rst_reg", 32'(dump_reg), 32'd0);
    checkOutput("rst_data", dump_data, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_count", 32'(cycle_count), 32'd0);
    checkOutput("rst_sel", 32'(rf_readRegA), 32'd17);
    checkOutput("rst_we", 32'(rf_writeEnable), 32'd1);

    reset = 1'b1;
    stepClock();
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Run 5 cycles with a stray start mid-RUN, then full dump with a stall on beat 7.
    busyCycles = 0;
    applyStimulus(1'b1, 16'd5, 1'b1);
    stepClock();
    applyStimulus(1'b0, 16'd5, 1'b1);
    checkOutput("run_busy", 32'(busy), 32'd1);
    checkOutput("run_we0", 32'(rf_writeEnable), 32'd1);
    checkOutput("run_sel", 32'(rf_readRegA), 32'd17);
    checkOutput("run_count0", 32'(cycle_count), 32'd0);
    for (int i = 1; i < 5; i++) begin
      stepClock();
      checkOutput("run_count", 32'(cycle_count), 32'(i));
      checkOutput("run_we", 32'(rf_writeEnable), 32'd1);
      if (i == 2) applyStimulus(1'b1, 16'd0, 1'b1);
      if (i == 3) applyStimulus(1'b0, 16'd5, 1'b1);
    end
    stepClock();
    checkOutput("scan_count", 32'(cycle_count), 32'd5);

    for (int k = FIRST; k < NUM_REGS; k++) begin
      checkOutput("scan_valid", 32'(dump_valid), 32'd0);
      checkOutput("scan_sel", 32'(rf_readRegA), 32'(k));
      checkOutput("scan_we", 32'(rf_writeEnable), 32'd0);
      if (k == 7) dump_ready = 1'b0;
      stepClock();
      if (k == 7) begin
        for (int s = 0; s < 3; s++) begin
          checkOutput("stall_valid", 32'(dump_valid), 32'd1);
          checkOutput("stall_reg", 32'(dump_reg), 32'd7);
          checkOutput("stall_data", dump_data, 32'd21);
          stepClock();
        end
        dump_ready = 1'b1;
      end
      checkOutput("hold_valid", 32'(dump_valid), 32'd1);
      checkOutput("hold_reg", 32'(dump_reg), 32'(k));
      checkOutput("hold_data", dump_data, 32'(3 * k));
      checkOutput("hold_we", 32'(rf_writeEnable), 32'd0);
      checkOutput("hold_sel", 32'(rf_readRegA), 32'(k));
      stepClock();
    end

    checkOutput("done_done", 32'(done), 32'd1);
    checkOutput("done_busy", 32'(busy), 32'd0);
    checkOutput("done_valid", 32'(dump_valid), 32'd0);
    checkOutput("done_count", 32'(cycle_count), 32'd5);
    checkOutput("done_we", 32'(rf_writeEnable), 32'd0);
    checkOutput("done_sel", 32'(rf_readRegA), 32'd17);
    checkOutput("busy_cycles", 32'(busyCycles), 32'(5 + 2 * NB + 3));
    stepClock();
    checkOutput("done_stay", 32'(done), 32'd1);
    checkOutput("done_count_hold", 32'(cycle_count), 32'd5);

    // Zero-length run restarted from DONE, then reset while holding beat 12.
    applyStimulus(1'b1, 16'd0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("zr_busy", 32'(busy), 32'd1);
    checkOutput("zr_sel", 32'(rf_readRegA), 32'(FIRST));
    checkOutput("zr_we", 32'(rf_writeEnable), 32'd0);
    checkOutput("zr_count", 32'(cycle_count), 32'd0);
    for (int k = FIRST; k <= 12; k++) begin
      stepClock();
      checkOutput("zr_reg", 32'(dump_reg), 32'(k));
      checkOutput("zr_data", dump_data, 32'(3 * k));
      if (k < 12) stepClock();
    end
    checkOutput("zr_count_hold", 32'(cycle_count), 32'd0);

    reset = 1'b0;
    stepClock();
    checkOutput("mrst_valid", 32'(dump_valid), 32'd0);
    checkOutput("mrst_reg", 32'(dump_reg), 32'd0);
    checkOutput("mrst_data", dump_data, 32'd0);
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    checkOutput("mrst_done", 32'(done), 32'd0);
    checkOutput("mrst_sel", 32'(rf_readRegA), 32'd17);
    checkOutput("mrst_we", 32'(rf_writeEnable), 32'd1);
    reset = 1'b1;

    applyStimulus(1'b1, 16'd1, 1'b1);
    stepClock();
    applyStimulus(1'b0, 16'd1, 1'b1);
    checkOutput("re_busy", 32'(busy), 32'd1);
    checkOutput("re_we", 32'(rf_writeEnable), 32'd1);
    stepClock();
    checkOutput("re_sel", 32'(rf_readRegA), 32'(FIRST));
    checkOutput("re_count", 32'(cycle_count), 32'd1);
    stepClock();
    checkOutput("re_reg", 32'(dump_reg), 32'(FIRST));
    checkOutput("re_data", dump_data, 32'(3 * FIRST));
    checkOutput("re_valid", 32'(dump_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/regfile_dump_ctrl.md
# regfile_dump_ctrl

Sequencer that runs the processor for a programmed number of cycles, freezes its register writes, and then scans all architectural registers out through read port A of the regfile. Each value is presented on a valid/ready stream. It sits between the processor and the regfile: it muxes `ctrl_readRegA` and gates `ctrl_writeEnable`. This gives synthesizable end-of-run register dumps on hardware, matching the register check the simulation harness performs.

## Interface
Parameters:
- `NUM_REGS`, 32, number of registers scanned; index width is fixed at 5 bits.
- `CYC_W`, 16, width of the run-cycle counter.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a run.
- `run_cycles`  in  CYC_W  processor cycles to run before dumping; sampled on the accepted `start`.
- `cpu_readRegA`  in  5  processor's read-port-A select.
- `cpu_writeEnable`  in  1  processor's regfile write enable.
- `rf_readRegA`  out  5  select driven to the regfile port A.
- `rf_writeEnable`  out  1  gated write enable to the regfile.
- `data_readRegA`  in  32  regfile port A data. The read is combinational.
- `dump_valid`  out  1  `dump_reg`/`dump_data` hold a beat.
- `dump_ready`  in  1  consumer accepts the beat.
- `dump_reg`  out  5  register index of the beat.
- `dump_data`  out  32  captured register value.
- `busy`  out  1  high in RUN, SCAN, HOLD.
- `done`  out  1  high in DONE.
- `cycle_count`  out  CYC_W  cycles elapsed in RUN.

## Operation
- States: IDLE, RUN, SCAN, HOLD, DONE.
- **IDLE**
  - `start` latches `run_cycles`, clears `cycle_count` and the index, and goes to RUN.
  - If the latched `run_cycles` is 0, go directly to SCAN.
- **RUN**
  - Mux is transparent: `rf_readRegA` = `cpu_readRegA`, `rf_writeEnable` = `cpu_writeEnable`.
  - `cycle_count` increments every clock.
  - When `cycle_count == latched-1`, go to SCAN.
- **SCAN**
  - `rf_writeEnable` = 0 and `rf_readRegA` = index.
  - On the next edge, capture `data_readRegA` into `dump_data` and index into `dump_reg`, set `dump_valid`, and go to HOLD.
- **HOLD**
  - Writes stay gated and the select stays on the index.
  - `dump_valid` stays 1 and `dump_reg`/`dump_data` stay stable until `dump_ready`.
  - On `valid && ready`: clear `dump_valid`.
    - If index == `NUM_REGS-1`, go to DONE.
    - Otherwise increment the index and go to SCAN.
- **DONE**
  - Writes stay gated and `rf_readRegA` = `cpu_readRegA`.
  - `done` = 1 and `cycle_count` holds.
  - `start` restarts exactly as from IDLE.
- `start` is ignored in RUN, SCAN and HOLD.
- Index arithmetic is 5-bit unsigned and never wraps past `NUM_REGS-1`.
- `cycle_count` saturates at all-ones.

## Timing
- Reset (`reset`=0 at an edge):
  - State → IDLE.
  - Outputs: `dump_valid`=0, `dump_reg`=0, `dump_data`=0, `busy`=0, `done`=0, `cycle_count`=0.
  - Mux is transparent. This applies from any state, including mid-scan with a beat pending; the pending beat is dropped.
- `start` at edge N → `busy`=1 after N. The first processor write is passed in cycle N+1.
- RUN lasts exactly `run_cycles` clocks. With R = `run_cycles`, the first SCAN is the cycle after edge N+R.
- Each beat takes a minimum of 2 cycles (SCAN + HOLD with `ready` already high).
  - A full dump without stalls takes 2·`NUM_REGS` cycles.
  - `done` asserts the cycle after the last handshake.
- `dump_ready` high while `dump_valid` is low has no effect.
- A write asserted by the processor on the last RUN cycle is passed through. The gate applies from the first SCAN cycle.

## Configuration
- `DUMP_SKIP_R0_EN` defined: the index starts at 1 and the dump emits `NUM_REGS-1` beats. r0 is never driven on `rf_readRegA` by the controller.
- `DUMP_SKIP_R0_EN` undefined: the index starts at 0 and the dump emits `NUM_REGS` beats.

## Test plan
- Regfile preloaded with rN=N·3, `run_cycles`=5, `start` pulse, `dump_ready` tied 1 → `busy` for 5+64 cycles; beats (0,0),(1,3)…(31,93); then `done`=1 and `cycle_count`=5.
- `cpu_writeEnable` held 1 throughout → `rf_writeEnable` high for exactly 5 RUN cycles, then 0 through SCAN, HOLD and DONE.
- `dump_ready` low for 3 cycles on beat 7 → `dump_valid`, `dump_reg`=7 and `dump_data` stable for all 3 cycles; beat 8 follows the acceptance.
- `run_cycles`=0 → SCAN the cycle after `start`; `cycle_count` stays 0. A second `start` mid-RUN is ignored.
- Reset (`reset`=0) while in HOLD on beat 12 → next cycle all outputs at reset values; a later `start` rescans from index 0.
- Build with `DUMP_SKIP_R0_EN` → the first beat is `dump_reg`=1, 31 beats total, and `done` follows beat 31.
